// File: rtl/inta_sequencer.sv
// 8086-mode 8259A interrupt-acknowledge initiator: two INTA pulses, vector capture, valid/ready hand-off, non-specific EOI.
// Latency: int_req rise to inta_n fall = 3 clk; vec_valid rises 1 clk after the final inta_n rise; vec held until vec_ready.
module inta_sequencer #(
    parameter int         INTA_LOW_CYC = 2,
    parameter int         INTA_GAP_CYC = 2,
    parameter int         WR_LOW_CYC   = 2,
    parameter logic [7:0] EOI_CMD      = 8'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       int_req,
    output logic       inta_n,
    input  logic [7:0] pic_d_in,
    output logic [7:0] pic_d_out,
    output logic       pic_cs_n,
    output logic       pic_wr_n,
    output logic       pic_a0,
    output logic       vec_valid,
    input  logic       vec_ready,
    output logic [7:0] vec,
    input  logic       svc_done,
    output logic       busy
);

    localparam int MAX_IG  = (INTA_LOW_CYC > INTA_GAP_CYC) ? INTA_LOW_CYC : INTA_GAP_CYC;
    localparam int MAX_CYC = (MAX_IG > WR_LOW_CYC) ? MAX_IG : WR_LOW_CYC;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    typedef enum logic [2:0] {
        IDLE, INTA1, GAP, INTA2, PRESENT, WAIT_DONE, EOI_WR, EOI_REC
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            int_meta, int_s;
    logic            counting;
    logic            inta_n_nxt, cs_n_nxt, wr_n_nxt, vec_valid_nxt;
    logic [7:0]      vec_nxt, d_out_nxt;

    always_comb begin
        state_nxt = state;
        vec_nxt   = vec;
        counting  = 1'b0;
        case (state)
            IDLE:      if (int_s) state_nxt = INTA1;
            INTA1: begin
                counting = 1'b1;
                if (cnt == CW'(INTA_LOW_CYC - 1)) state_nxt = GAP;
            end
            GAP: begin
                counting = 1'b1;
                if (cnt == CW'(INTA_GAP_CYC - 1)) state_nxt = INTA2;
            end
            INTA2: begin
                counting = 1'b1;
                // Capture on the edge that ends the last low cycle, while the PIC still drives the bus.
                if (cnt == CW'(INTA_LOW_CYC - 1)) begin
                    state_nxt = PRESENT;
                    vec_nxt   = pic_d_in;
                end
            end
            PRESENT:   if (vec_valid && vec_ready) state_nxt = WAIT_DONE;
            WAIT_DONE: if (svc_done) state_nxt = EOI_WR;
            EOI_WR: begin
                counting = 1'b1;
                if (cnt == CW'(WR_LOW_CYC - 1)) state_nxt = EOI_REC;
            end
            EOI_REC:   state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase

        cnt_nxt = (counting && state_nxt == state) ? cnt + CW'(1) : '0;

        // Strobes decode the next state so they switch on the same edge as the FSM and cannot overlap.
        inta_n_nxt    = !(state_nxt == INTA1 || state_nxt == INTA2);
        cs_n_nxt      = (state_nxt != EOI_WR);
        wr_n_nxt      = (state_nxt != EOI_WR);
        d_out_nxt     = (state_nxt == EOI_WR) ? EOI_CMD : pic_d_out;
        vec_valid_nxt = (state == PRESENT) && (state_nxt == PRESENT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_meta  <= 1'b0;
            int_s     <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
            inta_n    <= 1'b1;
            pic_cs_n  <= 1'b1;
            pic_wr_n  <= 1'b1;
            pic_d_out <= 8'h00;
            vec       <= 8'h00;
            vec_valid <= 1'b0;
        end else begin
            int_meta  <= int_req;
            int_s     <= int_meta;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            inta_n    <= inta_n_nxt;
            pic_cs_n  <= cs_n_nxt;
            pic_wr_n  <= wr_n_nxt;
            pic_d_out <= d_out_nxt;
            vec       <= vec_nxt;
            vec_valid <= vec_valid_nxt;
        end
    end

    assign pic_a0 = 1'b0;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: expected vectors queued when the PIC bus is driven, popped at the core hand-off.
module tb_inta_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       int_req;
    logic       inta_n;
    logic [7:0] pic_d_in;
    logic [7:0] pic_d_out;
    logic       pic_cs_n;
    logic       pic_wr_n;
    logic       pic_a0;
    logic       vec_valid;
    logic       vec_ready;
    logic [7:0] vec;
    logic       svc_done;
    logic       busy;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] sb[$];

    inta_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .int_req   (int_req),
        .inta_n    (inta_n),
        .pic_d_in  (pic_d_in),
        .pic_d_out (pic_d_out),
        .pic_cs_n  (pic_cs_n),
        .pic_wr_n  (pic_wr_n),
        .pic_a0    (pic_a0),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .vec       (vec),
        .svc_done  (svc_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_bad);
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] exp;
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: observed vector %0h with no expected entry queued", tag, vec);
        end else begin
            exp = sb.pop_front();
            chk(tag, {24'h0, vec}, {24'h0, exp});
        end
    endtask

    task automatic wait_inta_low(input int budget, output int waited);
        waited = 0;
        while (inta_n !== 1'b0 && waited < budget) begin
            tick;
            waited++;
        end
    endtask

    initial begin
        int         w;
        logic [6:0] exp_inta;

        reset     = 1'b1;
        int_req   = 1'b1;
        pic_d_in  = 8'hFF;
        vec_ready = 1'b0;
        svc_done  = 1'b0;
        exp_inta  = 7'b1001100;

        // Reset with int_req already high
        repeat (3) tick;
        chk("rst_inta_n",    inta_n,    1);
        chk("rst_cs_n",      pic_cs_n,  1);
        chk("rst_wr_n",      pic_wr_n,  1);
        chk("rst_a0",        pic_a0,    0);
        chk("rst_d_out",     pic_d_out, 0);
        chk("rst_vec",       vec,       0);
        chk("rst_vec_valid", vec_valid, 0);
        chk("rst_busy",      busy,      0);

        reset = 1'b0;
        wait_inta_low(10, w);
        chk("t1_inta_latency", w, 3);
        int_req = 1'b0;

        // Two-pulse INTA shape; vector only on the bus around the INTA2 capture edge
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick;
            if (i == 4) begin
                pic_d_in = 8'h4B;
                sb.push_back(8'h4B);
            end
            chk("t2_inta_n", inta_n, exp_inta[i]);
            chk("t2_valid_low", vec_valid, 0);
            if (i == 6) pic_d_in = 8'hA5;
        end
        chk("t2_vec_captured", vec, 8'h4B);
        tick;
        chk("t2_valid_rise", vec_valid, 1);

        // Backpressure with a stray svc_done while presenting
        for (int i = 0; i < 10; i++) begin
            tick;
            if (i == 3) svc_done = 1'b1;
            if (i == 4) svc_done = 1'b0;
            chk("t3_valid_held", vec_valid, 1);
            chk("t3_vec_stable", vec, 8'h4B);
            chk("t3_no_write",   pic_cs_n, 1);
        end
        vec_ready = 1'b1;
        pop_check("t3_vec_handoff");
        tick;
        vec_ready = 1'b0;
        chk("t3_valid_drop", vec_valid, 0);
        chk("t3_busy_wait",  busy, 1);

        // EOI write
        tick;
        tick;
        chk("t4_idle_cs_n", pic_cs_n, 1);
        svc_done = 1'b1;
        tick;
        svc_done = 1'b0;
        chk("t4_cs_n_c1",   pic_cs_n,  0);
        chk("t4_wr_n_c1",   pic_wr_n,  0);
        chk("t4_a0",        pic_a0,    0);
        chk("t4_d_out",     pic_d_out, 8'h20);
        chk("t4_inta_high", inta_n,    1);
        tick;
        chk("t4_cs_n_c2",   pic_cs_n,  0);
        chk("t4_wr_n_c2",   pic_wr_n,  0);
        tick;
        chk("t4_rec_cs_n",  pic_cs_n,  1);
        chk("t4_rec_wr_n",  pic_wr_n,  1);
        chk("t4_rec_d_out", pic_d_out, 8'h20);
        chk("t4_rec_busy",  busy,      1);
        tick;
        chk("t4_idle_busy", busy,      0);

        // Stray svc_done / vec_ready in IDLE
        svc_done  = 1'b1;
        vec_ready = 1'b1;
        tick;
        svc_done  = 1'b0;
        vec_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("t5_no_write", pic_cs_n,  1);
            chk("t5_no_valid", vec_valid, 0);
            chk("t5_idle",     busy,      0);
        end

        // Back-to-back interrupts with int_req held high, ready already asserted
        pic_d_in  = 8'h91;
        int_req   = 1'b1;
        vec_ready = 1'b1;
        sb.push_back(8'h91);
        wait_inta_low(10, w);
        chk("t6_inta_latency", w, 3);
        w = 0;
        while (vec_valid !== 1'b1 && w < 20) begin
            tick;
            w++;
        end
        chk("t6_valid_delay", w, 7);
        pop_check("t6_vec_handoff");
        tick;
        vec_ready = 1'b0;
        chk("t6_valid_drop", vec_valid, 0);
        svc_done = 1'b1;
        tick;
        svc_done = 1'b0;
        chk("t6_wr_n_c1", pic_wr_n, 0);
        tick;
        chk("t6_wr_n_c2", pic_wr_n, 0);
        tick;
        chk("t6_rec_wr_n",   pic_wr_n, 1);
        chk("t6_rec_inta_n", inta_n,   1);
        tick;
        chk("t6_gap_busy",   busy,     0);
        chk("t6_gap_inta_n", inta_n,   1);
        tick;
        chk("t6_restart_inta_n", inta_n, 0);

        // Abort the second sequence in GAP
        tick;
        tick;
        chk("t6_in_gap_inta_n", inta_n, 1);
        chk("t6_in_gap_busy",   busy,   1);
        reset   = 1'b1;
        int_req = 1'b0;
        #1;
        chk("t6_abort_inta_n", inta_n,    1);
        chk("t6_abort_busy",   busy,      0);
        chk("t6_abort_vec",    vec,       0);
        chk("t6_abort_d_out",  pic_d_out, 0);
        tick;
        reset = 1'b0;
        repeat (4) tick;
        chk("t6_post_busy",   busy,   0);
        chk("t6_post_inta_n", inta_n, 1);
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
